// File: rtl/bld_pkg.sv
// Shared constants for the blood-type lookup arbiter: ASCII allele codes,
// two-character phenotype codes and the arbiter FSM state encoding.
package bld_pkg;

   // ASCII allele characters accepted by the lookup
   localparam logic [7:0] CH_A = 8'h41;  // "A"
   localparam logic [7:0] CH_B = 8'h42;  // "B"
   localparam logic [7:0] CH_O = 8'h4F;  // "O"

   // Phenotype results, two ASCII characters, first character in [15:8]
   localparam logic [15:0] PH_A   = 16'h4120;  // "A "
   localparam logic [15:0] PH_B   = 16'h4220;  // "B "
   localparam logic [15:0] PH_AB  = 16'h4142;  // "AB"
   localparam logic [15:0] PH_O   = 16'h4F20;  // "O "
   localparam logic [15:0] PH_INV = 16'h3F3F;  // "??"

   // Arbiter FSM states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOOKUP = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

endpackage

// File: rtl/bld_pheno_lut.sv
// Combinational ABO phenotype lookup keyed on the ordered pair
// {maternal allele, paternal allele}. Any pair containing a character other
// than uppercase A, B or O maps to the invalid code "??".
module bld_pheno_lut
   import bld_pkg::*;
(
   input  logic [7:0]  allelm,
   input  logic [7:0]  allelf,
   output logic [15:0] pheno
);

   // Map the allele pair to its phenotype; unlisted pairs are invalid
   always_comb begin
      pheno = PH_INV;
      case ({allelm, allelf})
         {CH_A, CH_A}, {CH_A, CH_O}, {CH_O, CH_A}: pheno = PH_A;
         {CH_B, CH_B}, {CH_B, CH_O}, {CH_O, CH_B}: pheno = PH_B;
         {CH_A, CH_B}, {CH_B, CH_A}:               pheno = PH_AB;
         {CH_O, CH_O}:                             pheno = PH_O;
         default:                                  pheno = PH_INV;
      endcase
   end

endmodule

// File: rtl/bld_lookup_arbiter.sv
// Round-robin arbiter sharing one phenotype lookup between two lab stations.
// One transaction is in flight at a time: IDLE accepts a request, LOOKUP
// registers the table result, RESP holds the tagged response until consumed.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. reqN_ready is combinational and only asserted in IDLE for
// the granted station; rsp_valid is registered and rsp_* stay stable until
// rsp_ready is seen high with it.
//
// Optional build macro BLD_STATS_EN adds saturating per-station counters of
// served responses (srvN_cnt) and invalid-entry responses (errN_cnt).
module bld_lookup_arbiter
   import bld_pkg::*;
#(
   parameter int PRIO0_FIRST = 1,
   parameter int CNT_W       = 8
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   input  logic [7:0]        req0_allelm,
   input  logic [7:0]        req0_allelf,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [7:0]        req1_allelm,
   input  logic [7:0]        req1_allelf,
   output logic              req1_ready,
   output logic              rsp_valid,
   output logic              rsp_id,
   output logic [15:0]       rsp_pheno,
   output logic              rsp_err,
   input  logic              rsp_ready,
   output logic              busy
`ifdef BLD_STATS_EN
   ,
   output logic [CNT_W-1:0]  srv0_cnt,
   output logic [CNT_W-1:0]  srv1_cnt,
   output logic [CNT_W-1:0]  err0_cnt,
   output logic [CNT_W-1:0]  err1_cnt
`endif
);

   // last_grant value after reset: pointing at station 1 makes station 0 win
   // the first contention
   localparam logic LAST_GRANT_RST = (PRIO0_FIRST != 0);

   if (CNT_W < 1) begin : g_cnt_w_chk
      $error("CNT_W must be at least 1");
   end

   state_t      state_q, state_d;
   logic        last_grant_q, last_grant_d;
   logic [7:0]  lat_m_q, lat_m_d;
   logic [7:0]  lat_f_q, lat_f_d;
   logic        lat_id_q, lat_id_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic        rsp_id_q, rsp_id_d;
   logic [15:0] rsp_pheno_q, rsp_pheno_d;
   logic        rsp_err_q, rsp_err_d;

   logic        idle;
   logic        grant0;
   logic        grant1;
   logic [15:0] lut_pheno;

   bld_pheno_lut u_lut (
      .allelm (lat_m_q),
      .allelf (lat_f_q),
      .pheno  (lut_pheno)
   );

   // Grant selection: a lone requester wins; under contention the station
   // that was not granted last time wins
   always_comb begin
      idle   = (state_q == ST_IDLE);
      grant0 = idle & req0_valid & (~req1_valid |  last_grant_q);
      grant1 = idle & req1_valid & (~req0_valid | ~last_grant_q);
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   // Next-state and next-output computation for the IDLE/LOOKUP/RESP sequence
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      lat_m_d      = lat_m_q;
      lat_f_d      = lat_f_q;
      lat_id_d     = lat_id_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_pheno_d  = rsp_pheno_q;
      rsp_err_d    = rsp_err_q;
      case (state_q)
         ST_IDLE: begin
            if (grant0 | grant1) begin
               lat_m_d      = grant1 ? req1_allelm : req0_allelm;
               lat_f_d      = grant1 ? req1_allelf : req0_allelf;
               lat_id_d     = grant1;
               last_grant_d = grant1;
               state_d      = ST_LOOKUP;
            end
         end
         ST_LOOKUP: begin
            rsp_pheno_d = lut_pheno;
            rsp_err_d   = (lut_pheno == PH_INV);
            rsp_id_d    = lat_id_q;
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_valid_q & rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and registered outputs; reset drops any in-flight response
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         last_grant_q <= LAST_GRANT_RST;
         lat_m_q      <= 8'h00;
         lat_f_q      <= 8'h00;
         lat_id_q     <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_pheno_q  <= 16'h0000;
         rsp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         lat_m_q      <= lat_m_d;
         lat_f_q      <= lat_f_d;
         lat_id_q     <= lat_id_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_pheno_q  <= rsp_pheno_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_pheno = rsp_pheno_q;
   assign rsp_err   = rsp_err_q;
   assign busy      = (state_q != ST_IDLE);

`ifdef BLD_STATS_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] srv0_q, srv1_q, err0_q, err1_q;
   logic             rsp_done;

   assign rsp_done = (state_q == ST_RESP) & rsp_valid_q & rsp_ready;

   // Saturating counters of completed responses per station
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         srv0_q <= '0;
         srv1_q <= '0;
         err0_q <= '0;
         err1_q <= '0;
      end else if (rsp_done) begin
         if (!rsp_id_q && srv0_q != CNT_MAX) srv0_q <= srv0_q + CNT_W'(1);
         if ( rsp_id_q && srv1_q != CNT_MAX) srv1_q <= srv1_q + CNT_W'(1);
         if (!rsp_id_q && rsp_err_q && err0_q != CNT_MAX) err0_q <= err0_q + CNT_W'(1);
         if ( rsp_id_q && rsp_err_q && err1_q != CNT_MAX) err1_q <= err1_q + CNT_W'(1);
      end
   end

   assign srv0_cnt = srv0_q;
   assign srv1_cnt = srv1_q;
   assign err0_cnt = err0_q;
   assign err1_cnt = err1_q;
`endif

endmodule
